phys_reg_free_list: RTL
=======================

Name: phys_reg_free_list

Overview:
- Circular FIFO of free physical-register tags that sits upstream of the physical register storage built from ff_1r_1w cells.
- The rename stage pops a free tag each cycle to allocate a destination register. That tag becomes the write/read select for the storage cells.
- Commit pushes back tags of retired, overwritten mappings.
- Holds PREG_NUM-ARCH_NUM entries. Out of reset, all non-architectural tags are free.

Parameters:
- PREG_NUM, 64, total physical registers.
- ARCH_NUM, 32, architectural registers. Tags 0..ARCH_NUM-1 are mapped at reset and are never initially free.
- TAG_WIDTH, 6, width of a physical tag; must satisfy 2^TAG_WIDTH >= PREG_NUM.
- Derived, not overridable: DEPTH = PREG_NUM-ARCH_NUM (32); PTR_W = clog2(DEPTH) (5); CNT_W = clog2(DEPTH+1) (6).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- alloc_req_i, input, 1, rename requests one tag this cycle.
- alloc_valid_o, output, 1, list non-empty; the tag on alloc_tag_o is usable.
- alloc_tag_o, output, TAG_WIDTH, tag at head. Reads 0 when the list is empty.
- free_en_i, input, 1, commit returns a tag this cycle.
- free_tag_i, input, TAG_WIDTH, tag being returned.
- count_o, output, CNT_W, number of free tags held.
- empty_o, output, 1, count_o==0.
- full_o, output, 1, count_o==DEPTH.
- err_o, output, 1, sticky error flag; set on illegal push or pop, cleared only by rst.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high. All state updates on posedge clk.
- Reset:
  - head=0, tail=0, count=DEPTH, err=0.
  - entry[i] = ARCH_NUM+i for i in 0..DEPTH-1.
  - Post-reset outputs: alloc_valid_o=1, alloc_tag_o=ARCH_NUM, count_o=DEPTH, full_o=1, empty_o=0, err_o=0.
- Reads are combinational from the registered head:
  - alloc_valid_o = (count!=0).
  - alloc_tag_o = entry[head] if count!=0, else 0.
  - Zero-gated read, same style as the storage cells.
- Pop (alloc):
  - Granted when alloc_req_i && count!=0. The tag presented this cycle is consumed at the edge.
  - On grant: head <= head+1, wrapping DEPTH-1 -> 0.
  - alloc_req_i when empty: no state change; err <= 1.
- Push (free):
  - Accepted when free_en_i && count!=DEPTH.
  - On accept: entry[tail] <= free_tag_i, tail <= tail+1, wrapping DEPTH-1 -> 0.
  - free_en_i when full: write dropped, tail unchanged, err <= 1.
- Simultaneous pop and push:
  - Both evaluated against the start-of-cycle count, then count <= count + push - pop.
  - Empty + push + req: pop is denied (no same-cycle bypass) and err <= 1. The pushed tag becomes visible next cycle.
  - Full + push + pop: both occur in the same cycle and count stays DEPTH. The push is legal here because a slot is being vacated; push acceptance when full is therefore push && (count!=DEPTH || pop_granted), and no err is raised.
- Tag values: no range or duplicate checking on free_tag_i. Legality of the tag is the commit stage's responsibility.
- count_o is always head-to-tail occupancy and never exceeds DEPTH.
- Reset mid-operation: all pending pushes and pops are discarded. State returns to the full initial image regardless of prior contents; err cleared.
- Storage: DEPTH x TAG_WIDTH flops with synchronous write and no reset-independent init. The reset image is written by rst.

Test Plan:
- Reset then idle -> alloc_valid_o=1, alloc_tag_o=32, count_o=32, full_o=1, err_o=0.
- Assert alloc_req_i for 32 consecutive cycles -> tags 32,33,...,63 presented in order. Then empty_o=1, alloc_valid_o=0, alloc_tag_o=0, count_o=0, err_o=0.
- From empty:
  - Push tags 5, 9, 17 on three cycles -> count_o=3, alloc_tag_o=5.
  - Pop three times -> 5, 9, 17 in order.
  - Pop while empty -> err_o=1 and stays 1 until rst.
- Wrap-around:
  - Pop 30, push 30 (tags 100%64 pattern: 0..29), then pop 32.
  - Required order: 62, 63, 0, 1, ..., 29. head and tail wrap cleanly and count_o tracks each step.
- Full list, free_en_i=1 with tag 7 and alloc_req_i=1 same cycle -> tag 32 consumed, count_o stays 32, tag 7 stored at tail, err_o=0.
- Full list, free_en_i=1 with alloc_req_i=0 -> write dropped, err_o=1.
- Mid-operation reset after 10 pops -> next cycle count_o=32, alloc_tag_o=32, err_o=0.

Source files
------------

// File: rtl/phys_reg_free_list_if.sv
// Rename/commit side of the physical register free list:
// alloc pop, free push and occupancy/status.
interface phys_reg_free_list_if #(
    parameter int PREG_NUM  = 64,
    parameter int ARCH_NUM  = 32,
    parameter int TAG_WIDTH = 6
);
    localparam int DEPTH = PREG_NUM - ARCH_NUM;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                 alloc_req_i;
    logic                 alloc_valid_o;
    logic [TAG_WIDTH-1:0] alloc_tag_o;
    logic                 free_en_i;
    logic [TAG_WIDTH-1:0] free_tag_i;
    logic [CNT_W-1:0]     count_o;
    logic                 empty_o;
    logic                 full_o;
    logic                 err_o;

    modport master (
        output alloc_req_i,
        input  alloc_valid_o,
        input  alloc_tag_o,
        output free_en_i,
        output free_tag_i,
        input  count_o,
        input  empty_o,
        input  full_o,
        input  err_o
    );

    modport slave (
        input  alloc_req_i,
        output alloc_valid_o,
        output alloc_tag_o,
        input  free_en_i,
        input  free_tag_i,
        output count_o,
        output empty_o,
        output full_o,
        output err_o
    );
endinterface

// File: rtl/phys_reg_free_list.sv
// Circular FIFO of free physical-register tags; reset preloads
// every non-architectural tag so rename can allocate at once.
module phys_reg_free_list #(
    parameter int PREG_NUM  = 64,
    parameter int ARCH_NUM  = 32,
    parameter int TAG_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    phys_reg_free_list_if.slave   fl
);
    localparam int DEPTH = PREG_NUM - ARCH_NUM;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [TAG_WIDTH-1:0] entry [DEPTH];
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [CNT_W-1:0]     count;
    logic                 err;

    logic                 is_empty;
    logic                 is_full;
    logic                 pop_ok;
    logic                 push_ok;
    logic                 bad_op;
    logic [PTR_W-1:0]     head_nxt;
    logic [PTR_W-1:0]     tail_nxt;
    logic [CNT_W-1:0]     count_nxt;

    assign is_empty = (count == '0);
    assign is_full  = (count == CNT_FULL);

    // A full list may accept a push only when a pop frees a slot
    // in the same cycle; an empty list never bypasses a push.
    assign pop_ok  = fl.alloc_req_i && !is_empty;
    assign push_ok = fl.free_en_i && (!is_full || pop_ok);
    assign bad_op  = (fl.alloc_req_i && is_empty)
                   || (fl.free_en_i && !push_ok);

    assign head_nxt = (head == PTR_LAST) ? '0 : head + 1'b1;
    assign tail_nxt = (tail == PTR_LAST) ? '0 : tail + 1'b1;

    always_comb begin
        count_nxt = count;
        unique case ({push_ok, pop_ok})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= CNT_FULL;
            err   <= 1'b0;
        end else begin
            if (pop_ok)
                head <= head_nxt;
            if (push_ok)
                tail <= tail_nxt;
            count <= count_nxt;
            if (bad_op)
                err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                entry[i] <= TAG_WIDTH'(ARCH_NUM + i);
        end else if (push_ok) begin
            entry[tail] <= fl.free_tag_i;
        end
    end

    assign fl.alloc_valid_o = !is_empty;
    assign fl.alloc_tag_o   = is_empty ? '0 : entry[head];
    assign fl.count_o       = count;
    assign fl.empty_o       = is_empty;
    assign fl.full_o        = is_full;
    assign fl.err_o         = err;
endmodule
